// File: rtl/convolution_procesor_pkg.sv
// Shared definitions for the convolution processor index sequencer:
// the controller state encoding and the default geometry.
package convolution_procesor_pkg;

    // Default X/Y address width; sizes run 0 .. 2^ADDR_W-1.
    localparam int DEF_ADDR_W  = 5;

    // Default X/Y memory read latency in cycles.
    localparam int DEF_MEM_LAT = 1;

    // Controller states. The top maps these onto plain 3-bit constants
    // so the state register stays a legacy-friendly logic vector.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/convolution_procesor_index_sequencer_if.sv
// Host / datapath side bus of the index sequencer. The master modport is
// the host plus memory/MAC datapath; the slave modport is the sequencer.
interface convolution_procesor_index_sequencer_if
    import convolution_procesor_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    // Host request
    logic              start_i;
    logic [ADDR_W-1:0] sizeX_i;
    logic [ADDR_W-1:0] sizeY_i;

    // Host status
    logic              busy_o;
    logic              done_o;

    // X/Y memory read port
    logic              mem_rd_o;
    logic [ADDR_W-1:0] memX_addr_o;
    logic [ADDR_W-1:0] memY_addr_o;

    // MAC control
    logic              mac_clr_o;
    logic              mac_en_o;

    // Z memory write port
    logic              memZ_we_o;
    logic [ADDR_W:0]   memZ_addr_o;

    modport master (
        output start_i, sizeX_i, sizeY_i,
        input  busy_o, done_o, mem_rd_o, memX_addr_o, memY_addr_o,
               mac_clr_o, mac_en_o, memZ_we_o, memZ_addr_o
    );

    modport slave (
        input  start_i, sizeX_i, sizeY_i,
        output busy_o, done_o, mem_rd_o, memX_addr_o, memY_addr_o,
               mac_clr_o, mac_en_o, memZ_we_o, memZ_addr_o
    );

endinterface

// File: rtl/convolution_procesor_comparatorGreaterIqualThan.sv
// Unsigned greater-or-equal comparator used for every loop-bound decision
// in the sequencer, so all bound checks share one well-known primitive.
module convolution_procesor_comparatorGreaterIqualThan #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ge_o
);

    // Both operands are unsigned; no sign extension anywhere.
    assign ge_o = (a_i >= b_i);

endmodule

// File: rtl/convolution_procesor_strobe_delay.sv
// Fixed-latency strobe delay line. Turns the read strobe into the MAC
// enable so the accumulate lines up with data returning from memory.
module convolution_procesor_strobe_delay #(
    parameter int LAT = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic strobe_i,
    output logic strobe_o
);

    logic [LAT-1:0] pipe;

    // Shift the strobe one stage per cycle; cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: every stage is reset, so no stale enable can leak out
            // of the pipe after a mid-operation reset.
            pipe <= '0;
        end else begin
            // NOTE: non-blocking assignments let each stage take the old
            // value of its predecessor, giving a true shift register.
            pipe[0] <= strobe_i;
            for (int k = 1; k < LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign strobe_o = pipe[LAT-1];

endmodule

// File: rtl/convolution_procesor_index_sequencer.sv
// Index sequencer for the convolution processor. For each output index i it
// clears the MAC, streams the X[j]/Y[i-j] pairs that contribute to Z[i],
// waits for the memory pipeline to drain and then writes Z[i].
module convolution_procesor_index_sequencer
    import convolution_procesor_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    convolution_procesor_index_sequencer_if.slave bus
);

    localparam int IW    = ADDR_W + 1;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] CLR   = ST_CLR;
    localparam logic [2:0] READ  = ST_READ;
    localparam logic [2:0] DRAIN = ST_DRAIN;
    localparam logic [2:0] WRITE = ST_WRITE;
    localparam logic [2:0] DONE  = ST_DONE;

    logic [2:0]        state;
    logic [ADDR_W-1:0] size_x;
    logic [ADDR_W-1:0] size_y;
    logic [IW-1:0]     i_idx;      // output index i, one bit wider than sizes
    logic [ADDR_W-1:0] j_idx;      // X index j, drives memX_addr_o
    logic [ADDR_W-1:0] y_idx;      // Y index i-j, drives memY_addr_o
    logic [ADDR_W-1:0] j_end;      // last j for the current output
    logic [CNT_W-1:0]  drain_cnt;
    logic [IW-1:0]     z_addr;     // held Z address, updated only for a write

    // Comparator operands and results
    logic [IW-1:0]     cmp_end_a;
    logic [IW-1:0]     cmp_end_b;
    logic              ge_start;   // i >= sizeY
    logic              ge_end;     // CLR: i >= sizeX, READ: j >= jend
    logic              ge_last;    // i >= sizeX+sizeY-2
    logic [IW-1:0]     last_bound;

    // Per-output loop bounds
    logic [ADDR_W-1:0] j_start;
    logic [ADDR_W-1:0] y_start;
    logic [ADDR_W-1:0] j_end_next;
    logic              drain_last;

    // The sum is formed in IW bits so 2*(2^ADDR_W-1) cannot wrap. Both
    // sizes are nonzero whenever this is used, so the subtraction is safe.
    assign last_bound = {1'b0, size_x} + {1'b0, size_y} - IW'(2);

    // The jend/exit comparator is shared: CLR asks whether i has passed
    // the end of X, READ asks whether j has reached jend.
    always_comb begin
        // NOTE: defaults first so every path assigns both operands and no
        // latch can be inferred.
        cmp_end_a = i_idx;
        cmp_end_b = {1'b0, size_x};
        if (state == READ) begin
            cmp_end_a = {1'b0, j_idx};
            cmp_end_b = {1'b0, j_end};
        end
    end

    convolution_procesor_comparatorGreaterIqualThan #(.WIDTH(IW)) u_cmp_jstart (
        .a_i  (i_idx),
        .b_i  ({1'b0, size_y}),
        .ge_o (ge_start)
    );

    convolution_procesor_comparatorGreaterIqualThan #(.WIDTH(IW)) u_cmp_jend (
        .a_i  (cmp_end_a),
        .b_i  (cmp_end_b),
        .ge_o (ge_end)
    );

    convolution_procesor_comparatorGreaterIqualThan #(.WIDTH(IW)) u_cmp_last (
        .a_i  (i_idx),
        .b_i  (last_bound),
        .ge_o (ge_last)
    );

    // The true values always fit ADDR_W bits, so working modulo 2^ADDR_W
    // on the low bits of i gives exact results.
    assign j_start    = ge_start ? (i_idx[ADDR_W-1:0] - size_y + ADDR_W'(1)) : '0;
    assign y_start    = i_idx[ADDR_W-1:0] - j_start;
    assign j_end_next = ge_end ? (size_x - ADDR_W'(1)) : i_idx[ADDR_W-1:0];
    assign drain_last = (drain_cnt == CNT_W'(MEM_LAT - 1));

    // Controller: state, loop counters and held addresses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            size_x    <= '0;
            size_y    <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            y_idx     <= '0;
            j_end     <= '0;
            drain_cnt <= '0;
            z_addr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        size_x <= bus.sizeX_i;
                        size_y <= bus.sizeY_i;
                        i_idx  <= '0;
                        if (bus.sizeX_i == '0 || bus.sizeY_i == '0) begin
                            state <= DONE;
                        end else begin
                            state <= CLR;
                        end
                    end
                end
                CLR: begin
                    j_idx <= j_start;
                    y_idx <= y_start;
                    j_end <= j_end_next;
                    state <= READ;
                end
                READ: begin
                    // j stops on the last term so the addresses hold it
                    // while the strobe is low.
                    if (ge_end) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        j_idx <= j_idx + ADDR_W'(1);
                        y_idx <= y_idx - ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_last) begin
                        z_addr <= i_idx;
                        state  <= WRITE;
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    i_idx <= i_idx + IW'(1);
                    state <= ge_last ? DONE : CLR;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    convolution_procesor_strobe_delay #(.LAT(MEM_LAT)) u_mac_en_delay (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .strobe_i (bus.mem_rd_o),
        .strobe_o (bus.mac_en_o)
    );

    assign bus.busy_o      = (state == CLR) || (state == READ) ||
                             (state == DRAIN) || (state == WRITE);
    assign bus.done_o      = (state == DONE);
    assign bus.mem_rd_o    = (state == READ);
    assign bus.mac_clr_o   = (state == CLR);
    assign bus.memZ_we_o   = (state == WRITE);
    assign bus.memX_addr_o = j_idx;
    assign bus.memY_addr_o = y_idx;
    assign bus.memZ_addr_o = z_addr;

endmodule

// File: tb/tb_convolution_procesor_index_sequencer.sv
// Directed bench for the convolution index sequencer. Two instances are
// built, one with MEM_LAT=1 and one with MEM_LAT=3; sel picks which one is
// started and observed. A memory/MAC model driven by the DUT's strobes
// turns the reads into Z values for comparison with hand-computed results.
module tb_convolution_procesor_index_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic sel;
    logic [4:0] sx;
    logic [4:0] sy;

    always #5 clk = ~clk;

    convolution_procesor_index_sequencer_if #(.ADDR_W(5)) bus1 ();
    convolution_procesor_index_sequencer_if #(.ADDR_W(5)) bus3 ();

    assign bus1.start_i = start & ~sel;
    assign bus1.sizeX_i = sx;
    assign bus1.sizeY_i = sy;
    assign bus3.start_i = start & sel;
    assign bus3.sizeX_i = sx;
    assign bus3.sizeY_i = sy;

    convolution_procesor_index_sequencer #(.ADDR_W(5), .MEM_LAT(1)) dut1 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus1)
    );

    convolution_procesor_index_sequencer #(.ADDR_W(5), .MEM_LAT(3)) dut3 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus3)
    );

    // Observed outputs of the selected instance
    logic       m_busy, m_done, m_rd, m_clr, m_en, m_we;
    logic [4:0] m_x, m_y;
    logic [5:0] m_z;

    assign m_busy = sel ? bus3.busy_o      : bus1.busy_o;
    assign m_done = sel ? bus3.done_o      : bus1.done_o;
    assign m_rd   = sel ? bus3.mem_rd_o    : bus1.mem_rd_o;
    assign m_clr  = sel ? bus3.mac_clr_o   : bus1.mac_clr_o;
    assign m_en   = sel ? bus3.mac_en_o    : bus1.mac_en_o;
    assign m_we   = sel ? bus3.memZ_we_o   : bus1.memZ_we_o;
    assign m_x    = sel ? bus3.memX_addr_o : bus1.memX_addr_o;
    assign m_y    = sel ? bus3.memY_addr_o : bus1.memY_addr_o;
    assign m_z    = sel ? bus3.memZ_addr_o : bus1.memZ_addr_o;

    int tests_run    = 0;
    int tests_failed = 0;

    // Memory contents seen by the MAC model
    int xm [32];
    int ym [32];

    // Per-run log
    int rd_x_q[$], rd_y_q[$], rd_cyc_q[$], en_cyc_q[$], we_cyc_q[$];
    int z_addr_q[$], z_val_q[$];
    int done_cyc, viol, hold_viol, busy_viol;

    function automatic logic [21:0] outs();
        return {m_busy, m_done, m_rd, m_x, m_y, m_clr, m_en, m_we, m_z};
    endfunction

    // Start the selected DUT and log one full run, cycle by cycle. Cycle c
    // is the clock period that follows the c-th edge after the start edge.
    // rp_a/rp_b re-pulse start_i in those cycles (0 = never).
    task automatic run_seq(input int sx_v, input int sy_v, input int budget,
                           input int rp_a, input int rp_b);
        int pend_x[$];
        int pend_y[$];
        int acc;
        logic [4:0] px, py;
        logic [5:0] pz;
        rd_x_q.delete(); rd_y_q.delete(); rd_cyc_q.delete();
        en_cyc_q.delete(); we_cyc_q.delete();
        z_addr_q.delete(); z_val_q.delete();
        done_cyc = -1; viol = 0; hold_viol = 0; busy_viol = 0; acc = 0;
        @(negedge clk);
        sx = 5'(sx_v);
        sy = 5'(sy_v);
        start = 1'b1;
        px = m_x; py = m_y; pz = m_z;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (m_busy !== ~m_done) busy_viol++;
            if (m_clr && m_en) viol++;
            if (m_we && m_en) viol++;
            if (!m_rd && (m_x !== px || m_y !== py)) hold_viol++;
            if (!m_we && m_z !== pz) hold_viol++;
            if (m_clr) acc = 0;
            if (m_en) begin
                en_cyc_q.push_back(c);
                if (pend_x.size() == 0) viol++;
                else acc += xm[pend_x.pop_front()] * ym[pend_y.pop_front()];
            end
            if (m_rd) begin
                pend_x.push_back(int'(m_x));
                pend_y.push_back(int'(m_y));
                rd_x_q.push_back(int'(m_x));
                rd_y_q.push_back(int'(m_y));
                rd_cyc_q.push_back(c);
            end
            if (m_we) begin
                z_addr_q.push_back(int'(m_z));
                z_val_q.push_back(acc);
                we_cyc_q.push_back(c);
            end
            px = m_x; py = m_y; pz = m_z;
            // Sizes are don't-care once latched; scramble them.
            sx = 5'd17;
            sy = 5'd9;
            start = (c == rp_a || c == rp_b) ? 1'b1 : 1'b0;
            if (m_done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic load_small();
        for (int k = 0; k < 32; k++) begin
            xm[k] = 0;
            ym[k] = 0;
        end
        xm[0] = 1; xm[1] = 2; xm[2] = 3;
        ym[0] = 1; ym[1] = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sel = 1'b0; sx = '0; sy = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (outs() !== 22'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs_lat1: got %h expected 0", outs());
        end
        sel = 1'b1;
        #1;
        tests_run++;
        if (outs() !== 22'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs_lat3: got %h expected 0", outs());
        end
        sel = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (outs() !== 22'd0) begin
            tests_failed++;
            $display("FAIL reset_idle_after_release: got %h expected 0", outs());
        end
    endtask

    task automatic test_basic();
        int exp_x [6] = '{0, 0, 1, 1, 2, 2};
        int exp_y [6] = '{0, 1, 0, 1, 0, 1};
        int exp_z [4] = '{1, 3, 5, 3};
        int bad;
        sel = 1'b0;
        load_small();
        run_seq(3, 2, 60, 0, 0);
        tests_run++;
        if (done_cyc !== 19) begin
            tests_failed++;
            $display("FAIL basic_done_cycle: got %0d expected 19", done_cyc);
        end
        tests_run++;
        if (rd_x_q.size() != 6) begin
            tests_failed++;
            $display("FAIL basic_read_count: got %0d expected 6", rd_x_q.size());
        end
        bad = 0;
        for (int k = 0; k < 6 && k < rd_x_q.size(); k++)
            if (rd_x_q[k] != exp_x[k] || rd_y_q[k] != exp_y[k]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL basic_read_pairs: got %0d wrong pairs expected 0", bad);
        end
        bad = 0;
        for (int k = 0; k < 4 && k < z_addr_q.size(); k++)
            if (z_addr_q[k] != k) bad++;
        tests_run++;
        if (z_addr_q.size() != 4 || bad != 0) begin
            tests_failed++;
            $display("FAIL basic_z_addrs: got %0d writes, %0d wrong expected 4, 0",
                     z_addr_q.size(), bad);
        end
        bad = 0;
        for (int k = 0; k < 4 && k < z_val_q.size(); k++)
            if (z_val_q[k] != exp_z[k]) bad++;
        tests_run++;
        if (z_val_q.size() != 4 || bad != 0) begin
            tests_failed++;
            $display("FAIL basic_z_values: got %0d wrong of %0d expected 0 of 4",
                     bad, z_val_q.size());
        end
        tests_run++;
        if (viol != 0) begin
            tests_failed++;
            $display("FAIL basic_strobe_rules: got %0d violations expected 0", viol);
        end
        tests_run++;
        if (hold_viol != 0) begin
            tests_failed++;
            $display("FAIL basic_addr_hold: got %0d violations expected 0", hold_viol);
        end
        tests_run++;
        if (busy_viol != 0) begin
            tests_failed++;
            $display("FAIL basic_busy: got %0d bad cycles expected 0", busy_viol);
        end
    endtask

    task automatic test_zero_size();
        int sizes [2][2] = '{'{0, 2}, '{3, 0}};
        sel = 1'b0;
        for (int t = 0; t < 2; t++) begin
            run_seq(sizes[t][0], sizes[t][1], 20, 0, 0);
            tests_run++;
            if (done_cyc !== 1) begin
                tests_failed++;
                $display("FAIL zero_done_cycle[%0d]: got %0d expected 1", t, done_cyc);
            end
            tests_run++;
            if (rd_x_q.size() != 0 || z_addr_q.size() != 0) begin
                tests_failed++;
                $display("FAIL zero_no_access[%0d]: got %0d reads %0d writes expected 0 0",
                         t, rd_x_q.size(), z_addr_q.size());
            end
            tests_run++;
            if (busy_viol != 0) begin
                tests_failed++;
                $display("FAIL zero_busy[%0d]: got %0d bad cycles expected 0", t, busy_viol);
            end
        end
    endtask

    task automatic test_latency3();
        int bad;
        sel = 1'b1;
        load_small();
        xm[0] = 5; ym[0] = 7;
        run_seq(1, 1, 30, 0, 0);
        tests_run++;
        if (rd_cyc_q.size() != 1 || rd_cyc_q[0] != 2) begin
            tests_failed++;
            $display("FAIL lat3_read_cycle: got %0d reads first at %0d expected 1 at 2",
                     rd_cyc_q.size(), rd_cyc_q.size() ? rd_cyc_q[0] : -1);
        end
        tests_run++;
        if (en_cyc_q.size() != 1 || en_cyc_q[0] != 5) begin
            tests_failed++;
            $display("FAIL lat3_mac_en_cycle: got %0d enables first at %0d expected 1 at 5",
                     en_cyc_q.size(), en_cyc_q.size() ? en_cyc_q[0] : -1);
        end
        tests_run++;
        if (we_cyc_q.size() != 1 || we_cyc_q[0] != 6 || z_addr_q[0] != 0) begin
            tests_failed++;
            $display("FAIL lat3_write: got %0d writes first at %0d expected 1 at 6 addr 0",
                     we_cyc_q.size(), we_cyc_q.size() ? we_cyc_q[0] : -1);
        end
        tests_run++;
        if (done_cyc !== 7 || z_val_q.size() != 1 || z_val_q[0] != 35) begin
            tests_failed++;
            $display("FAIL lat3_done_value: got done %0d z %0d expected 7 35",
                     done_cyc, z_val_q.size() ? z_val_q[0] : -1);
        end
        load_small();
        run_seq(3, 2, 80, 0, 0);
        bad = 0;
        if (z_val_q.size() != 4) bad++;
        else if (z_val_q[0] != 1 || z_val_q[1] != 3 || z_val_q[2] != 5 || z_val_q[3] != 3) bad++;
        tests_run++;
        if (done_cyc !== 27 || bad != 0 || viol != 0) begin
            tests_failed++;
            $display("FAIL lat3_3x2: got done %0d bad %0d viol %0d expected 27 0 0",
                     done_cyc, bad, viol);
        end
    endtask

    task automatic test_max_size();
        int bad;
        int s;
        sel = 1'b0;
        for (int k = 0; k < 32; k++) begin
            xm[k] = k + 1;
            ym[k] = (k * 7) % 5 + 1;
        end
        run_seq(31, 31, 1300, 0, 0);
        tests_run++;
        if (z_addr_q.size() != 61) begin
            tests_failed++;
            $display("FAIL max_write_count: got %0d expected 61", z_addr_q.size());
        end
        bad = 0;
        for (int k = 0; k < z_addr_q.size(); k++)
            if (z_addr_q[k] != k) bad++;
        tests_run++;
        if (bad != 0 || z_addr_q.size() == 0 || z_addr_q[z_addr_q.size()-1] != 60) begin
            tests_failed++;
            $display("FAIL max_z_addrs: got %0d out of order, last %0d expected 0, 60",
                     bad, z_addr_q.size() ? z_addr_q[z_addr_q.size()-1] : -1);
        end
        tests_run++;
        if (rd_x_q.size() != 961) begin
            tests_failed++;
            $display("FAIL max_read_count: got %0d expected 961", rd_x_q.size());
        end
        tests_run++;
        if (done_cyc !== 1145) begin
            tests_failed++;
            $display("FAIL max_done_cycle: got %0d expected 1145", done_cyc);
        end
        bad = 0;
        for (int i = 0; i < 61 && i < z_val_q.size(); i++) begin
            s = 0;
            for (int j = 0; j < 31; j++)
                if (i - j >= 0 && i - j < 31) s += xm[j] * ym[i - j];
            if (z_val_q[i] != s) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL max_z_values: got %0d wrong expected 0", bad);
        end
        tests_run++;
        if (viol != 0 || hold_viol != 0) begin
            tests_failed++;
            $display("FAIL max_rules: got %0d strobe %0d hold expected 0 0", viol, hold_viol);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        sel = 1'b0;
        load_small();
        run_seq(3, 2, 60, 5, 10);
        tests_run++;
        if (done_cyc !== 19) begin
            tests_failed++;
            $display("FAIL restart_done_cycle: got %0d expected 19", done_cyc);
        end
        tests_run++;
        if (rd_x_q.size() != 6 || z_addr_q.size() != 4) begin
            tests_failed++;
            $display("FAIL restart_counts: got %0d reads %0d writes expected 6 4",
                     rd_x_q.size(), z_addr_q.size());
        end
        bad = 0;
        if (z_val_q.size() != 4) bad++;
        else if (z_val_q[0] != 1 || z_val_q[1] != 3 || z_val_q[2] != 5 || z_val_q[3] != 3) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL restart_z_values: got %0d bad expected 0", bad);
        end
        // A start seen only during DONE must not launch a run.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_busy || m_rd || m_clr || m_we) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL done_start_ignored: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int bad;
        sel = 1'b0;
        load_small();
        seen = 1'b0;
        @(negedge clk);
        sx = 5'd3; sy = 5'd2; start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_rd && m_en) begin
                seen = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL reset_mid_reach_read: got no READ with mac_en expected one");
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (outs() !== 22'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_async_clear: got %h expected 0", outs());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (m_busy || m_done || m_rd || m_we || m_clr || m_en) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_stays_idle: got %0d active cycles expected 0", bad);
        end
        run_seq(3, 2, 60, 0, 0);
        bad = 0;
        if (z_val_q.size() != 4) bad++;
        else if (z_val_q[0] != 1 || z_val_q[1] != 3 || z_val_q[2] != 5 || z_val_q[3] != 3) bad++;
        tests_run++;
        if (done_cyc !== 19 || bad != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_rerun: got done %0d bad %0d expected 19 0", done_cyc, bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_size();
        test_latency3();
        test_max_size();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
